operand_fetch_stage: RTL and testbench

Decode and operand-fetch stage sitting directly upstream of the 16-bit execution unit. Accepts 16-bit instruction words over a valid/ready handshake, decodes them, and holds a 16 x 16 register file with a per-register pending scoreboard. Issues the opcode, operands and immediate to the execution unit through a registered output. Receives the unit's result back over a writeback port.

---
 rtl/operand_fetch_stage.sv | 121 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: 16x16 register file with a pending scoreboard,
// RAW/WAW stall, writeback bypass and a registered issue port to the execution unit.
module operand_fetch_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_instr_valid,
  input  logic [15:0]       i_instr,
  output logic              o_instr_ready,
  output logic              o_ex_valid,
  input  logic              i_ex_ready,
  output logic [3:0]        o_ex_opcode,
  output logic [DATA_W-1:0] o_ex_src1,
  output logic [DATA_W-1:0] o_ex_src2,
  output logic [DATA_W-1:0] o_ex_immediate,
  output logic [3:0]        o_ex_rd,
  input  logic              i_wb_en,
  input  logic [3:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_err_illegal
);

  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic [NREGS-1:0]             r_pending;
  logic                         r_ex_valid;
  logic [3:0]                   r_ex_opcode;
  logic [DATA_W-1:0]            r_ex_src1;
  logic [DATA_W-1:0]            r_ex_src2;
  logic [DATA_W-1:0]            r_ex_imm;
  logic [3:0]                   r_ex_rd;
  logic                         r_err;

  logic [3:0]        w_op;
  logic [3:0]        w_rd;
  logic [3:0]        w_rs1;
  logic [3:0]        w_rs2;
  logic              w_legal;
  logic              w_use1;
  logic              w_use2;
  logic [NREGS-1:0]  w_clr;
  logic [NREGS-1:0]  w_eff_pend;
  logic [NREGS-1:0]  w_set;
  logic              w_hazard;
  logic              w_ready;
  logic              w_accept;
  logic              w_issue;
  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;

  assign w_op    = i_instr[15:12];
  assign w_rd    = i_instr[11:8];
  assign w_rs1   = i_instr[7:4];
  assign w_rs2   = i_instr[3:0];
  assign w_legal = (w_op <= 4'd8);
  assign w_use1  = (w_op <= 4'd7);
  assign w_use2  = (w_op <= 4'd6);

  // A writeback this cycle already counts as resolved for hazard purposes.
  assign w_clr      = i_wb_en ? (NREGS'(1) << i_wb_addr) : '0;
  assign w_eff_pend = r_pending & ~w_clr;

  assign w_hazard = w_legal && ((w_use1 && w_eff_pend[w_rs1]) ||
                                (w_use2 && w_eff_pend[w_rs2]) ||
                                w_eff_pend[w_rd]);
  assign w_ready  = !w_hazard && (!r_ex_valid || i_ex_ready);
  assign w_accept = i_instr_valid && w_ready;
  assign w_issue  = w_accept && w_legal;
  assign w_set    = (w_issue && w_rd != 4'd0) ? (NREGS'(1) << w_rd) : '0;

  // Operand read with writeback bypass; unused sources are forced to zero.
  always_comb begin
    w_src1 = '0;
    w_src2 = '0;
    if (w_use1 && w_rs1 != 4'd0)
      w_src1 = (i_wb_en && i_wb_addr == w_rs1) ? i_wb_data : r_regs[w_rs1];
    if (w_use2 && w_rs2 != 4'd0)
      w_src2 = (i_wb_en && i_wb_addr == w_rs2) ? i_wb_data : r_regs[w_rs2];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_regs      <= '0;
      r_pending   <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_opcode <= '0;
      r_ex_src1   <= '0;
      r_ex_src2   <= '0;
      r_ex_imm    <= '0;
      r_ex_rd     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (i_wb_en && i_wb_addr != 4'd0)
        r_regs[i_wb_addr] <= i_wb_data;
      // Set is OR'd after the clear so a same-register set wins.
      r_pending <= w_eff_pend | w_set;
      r_err     <= w_accept && !w_legal;
      if (w_issue) begin
        r_ex_valid  <= 1'b1;
        r_ex_opcode <= w_op;
        r_ex_src1   <= w_src1;
        r_ex_src2   <= w_src2;
        r_ex_imm    <= {{(DATA_W-8){1'b0}}, i_instr[7:0]};
        r_ex_rd     <= w_rd;
      end else if (i_ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign o_instr_ready  = w_ready;
  assign o_ex_valid     = r_ex_valid;
  assign o_ex_opcode    = r_ex_opcode;
  assign o_ex_src1      = r_ex_src1;
  assign o_ex_src2      = r_ex_src2;
  assign o_ex_immediate = r_ex_imm;
  assign o_ex_rd        = r_ex_rd;
  assign o_err_illegal  = r_err;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: expected issues are queued on
// acceptance and compared when the execution unit takes them.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instr_ready;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_src1, ex_src2, ex_imm;
  logic [3:0]  ex_rd;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = 4'h0;
  logic [15:0] wb_data = 16'h0;
  logic        err_illegal;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr_valid(instr_valid), .i_instr(instr), .o_instr_ready(instr_ready),
    .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
    .o_ex_opcode(ex_opcode), .o_ex_src1(ex_src1), .o_ex_src2(ex_src2),
    .o_ex_immediate(ex_imm), .o_ex_rd(ex_rd),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_err_illegal(err_illegal)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] imm;
    logic [3:0]  rd;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_regs [16];
  int          total = 0;
  int          bad = 0;

  function automatic exp_t model_exp(input logic [15:0] ins);
    exp_t e;
    e.op  = ins[15:12];
    e.rd  = ins[11:8];
    e.imm = {8'h00, ins[7:0]};
    e.s1  = (ins[15:12] <= 4'd7 && ins[7:4] != 4'd0) ? m_regs[ins[7:4]] : 16'h0;
    e.s2  = (ins[15:12] <= 4'd6 && ins[3:0] != 4'd0) ? m_regs[ins[3:0]] : 16'h0;
    return e;
  endfunction

  // Scoreboard pop on every execution-unit handshake.
  always @(negedge clk) begin
    exp_t got, e;
    if (rst_n && ex_valid && ex_ready) begin
      got = {ex_opcode, ex_src1, ex_src2, ex_imm, ex_rd};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected got=%h required=none", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL issue_data got=%h required=%h", got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_wb(input logic [3:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    if (a != 4'd0) m_regs[a] = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins);
    int n = 0;
    instr = ins; instr_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (instr_ready) break;
      n++;
      if (n > 40) break;
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_timeout instr=%h ready=%b required=1", ins, instr_ready);
    end else if (ins[15:12] <= 4'd8) begin
      q.push_back(model_exp(ins));
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ex_valid, err_illegal, ex_opcode, ex_src1, ex_src2, ex_imm, ex_rd} !== 58'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0",
               {ex_valid, err_illegal, ex_opcode, ex_src1, ex_src2, ex_imm, ex_rd});
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b required=1", instr_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_add;
    issue(16'h835A);            // r3 <- imm 0x5A
    do_wb(4'd3, 16'h005A);
    issue(16'h0433);            // ADD r4, r3, r3
  endtask

  task automatic test_raw;
    do_wb(4'd1, 16'h1111);
    do_wb(4'd2, 16'h2222);
    issue(16'h1512);            // SUB r5, r1, r2
    instr = 16'h2651; instr_valid = 1'b1;   // AND r6, r5, r1
    repeat (2) begin
      @(negedge clk);
      total++;
      if (instr_ready !== 1'b0) begin
        bad++; $display("FAIL raw_stall ready=%b required=0", instr_ready);
      end
      @(posedge clk); #1;
    end
    do_wb_and_accept(4'd5, 16'h1234, "raw_bypass");
  endtask

  // Writeback and a dependent instruction in the same cycle: must accept at that edge.
  task automatic do_wb_and_accept(input logic [3:0] a, input logic [15:0] d, input string nm);
    wb_en = 1'b1; wb_addr = a; wb_data = d; m_regs[a] = d;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready=%b required=1", nm, instr_ready);
    end else begin
      q.push_back(model_exp(instr));
    end
    @(posedge clk); #1;
    wb_en = 1'b0; instr_valid = 1'b0;
  endtask

  task automatic test_waw;
    issue(16'h3712);            // OR r7, r1, r2
    instr = 16'h4712; instr_valid = 1'b1;   // XOR r7, r1, r2
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b0) begin
      bad++; $display("FAIL waw_stall ready=%b required=0", instr_ready);
    end
    @(posedge clk); #1;
    do_wb_and_accept(4'd7, 16'hAAAA, "waw_release");
    instr = 16'h5870; instr_valid = 1'b1;   // reads r7: must still see it pending
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b0) begin
      bad++; $display("FAIL waw_set_wins ready=%b required=0", instr_ready);
    end
    @(posedge clk); #1;
    do_wb_and_accept(4'd7, 16'hBBBB, "waw_second_wb");
  endtask

  task automatic test_backpressure;
    exp_t e;
    e = model_exp(16'h6912);
    issue(16'h6912);
    ex_ready = 1'b0;
    instr = 16'h6A12; instr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (!ex_valid || {ex_opcode, ex_src1, ex_src2, ex_imm, ex_rd} !== e) begin
        bad++;
        $display("FAIL bp_hold got=%b/%h required=1/%h", ex_valid,
                 {ex_opcode, ex_src1, ex_src2, ex_imm, ex_rd}, e);
      end
      total++;
      if (instr_ready !== 1'b0) begin
        bad++; $display("FAIL bp_ready ready=%b required=0", instr_ready);
      end
    end
    @(posedge clk); #1;
    ex_ready = 1'b1;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release ready=%b required=1", instr_ready);
    end else begin
      q.push_back(model_exp(instr));
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_r0;
    instr = 16'hF123; instr_valid = 1'b1;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_ready ready=%b required=1", instr_ready);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    total++;
    if (err_illegal !== 1'b1 || ex_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_pulse err=%b ex_valid=%b required=1/0", err_illegal, ex_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (err_illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_one_cycle err=%b required=0", err_illegal);
    end
    @(posedge clk); #1;
    do_wb(4'd0, 16'hFFFF);
    instr = 16'h7100; instr_valid = 1'b1;   // NOT r1, r0; r1 must not be pending
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_no_pending ready=%b required=1", instr_ready);
    end else begin
      q.push_back(model_exp(instr));
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] ins;
    do_wb(4'd1, 16'h0101);
    do_wb(4'd2, 16'h0202);
    for (int i = 0; i < 4; i++) begin
      ins = {4'(i), 4'(12 + i), 4'h1, 4'h2};
      instr = ins; instr_valid = 1'b1;
      @(negedge clk);
      total++;
      if (instr_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready idx=%0d ready=%b required=1", i, instr_ready);
      end else begin
        q.push_back(model_exp(ins));
      end
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    issue(16'h8200);            // r2 pending
    ex_ready = 1'b0;
    @(negedge clk);
    total++;
    if (ex_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_pre ex_valid=%b required=1", ex_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h7777;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; wb_en = 1'b0; ex_ready = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    instr = 16'h0B22; instr_valid = 1'b1;   // ADD r11, r2, r2
    @(negedge clk);
    total++;
    if (ex_valid !== 1'b0 || ex_opcode !== 4'h0 || ex_rd !== 4'h0) begin
      bad++; $display("FAIL midrst_ex ex_valid=%b op=%h rd=%h required=0/0/0", ex_valid, ex_opcode, ex_rd);
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_pend2 ready=%b required=1", instr_ready);
    end else begin
      q.push_back(model_exp(instr));
    end
    @(posedge clk); #1;
    instr = 16'h1444;           // r4 was pending before reset
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_pend4 ready=%b required=1", instr_ready);
    end else begin
      q.push_back(model_exp(instr));
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    test_reset;
    test_load_add;
    test_raw;
    test_waw;
    test_backpressure;
    test_illegal_r0;
    test_back_to_back;
    test_reset_midop;
    ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
